// File: rtl/hls_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hls_batch_sequencer
// Description : Walks a batch of arguments through an ap_ctrl_hs HLS core.
//               For each index it reads the argument RAM (two-edge read
//               latency) and passes the argument to the core. It then writes
//               the core result, or all-ones on a watchdog expiry, to the
//               result RAM at the same index.
//   clk, rst            : single clock, synchronous active-high reset
//   start, count        : batch launch and entry count (sampled in IDLE)
//   busy, done          : status; done is a one-cycle end-of-batch pulse
//   timeout_err         : sticky watchdog flag, cleared by the next start
//   in_addr, in_q       : argument RAM read port
//   out_addr/out_d/we   : result RAM write port
//   ap_start/ap_done/ap_idle/ap_ready, ap_n, ap_return : HLS core interface
// Revision    : 1.0 - initial release
// ============================================================================
module hls_batch_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3,
    parameter int ARG_WIDTH  = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_q,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_d,
    output logic                  out_we,
    output logic                  ap_start,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    input  logic                  ap_ready,
    output logic [ARG_WIDTH-1:0]  ap_n,
    input  logic [DATA_WIDTH-1:0] ap_return
);

    localparam int                WDOG_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_ADDR   = 4'd1,
        S_RD_WAIT   = 4'd2,
        S_RD_CAP    = 4'd3,
        S_CALL      = 4'd4,
        S_WAIT_DONE = 4'd5,
        S_WRITE     = 4'd6,
        S_NEXT      = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    idx_q, idx_d, idx_inc;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d, wdog_step;
    logic                   wdog_hit;
    logic [ARG_WIDTH-1:0]   ap_n_q, ap_n_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   busy_q, done_q, ap_start_q, out_we_q;

    // ap_idle is status only; in_q upper bits are truncated away.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{ap_idle, in_q};

    assign idx_inc   = idx_q + IDX_ONE;
    assign wdog_hit  = (wdog_q == WDOG_LIMIT);
    // Saturate so the watchdog never wraps while waiting in WAIT_DONE.
    assign wdog_step = wdog_hit ? wdog_q : (wdog_q + WDOG_ONE);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        wdog_d        = wdog_q;
        ap_n_d        = ap_n_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d       = count;
                    idx_d         = '0;
                    timeout_err_d = 1'b0;
                    state_d       = (count != '0) ? S_RD_ADDR : S_FINISH;
                end
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_CAP;
            S_RD_CAP: begin
                ap_n_d  = in_q[ARG_WIDTH-1:0];
                wdog_d  = '0;
                state_d = S_CALL;
            end
            S_CALL: begin
                wdog_d = wdog_step;
                if (ap_ready) begin
                    if (ap_done) begin
                        // Core finished in the accept cycle itself.
                        result_d = ap_return;
                        state_d  = S_WRITE;
                    end else begin
                        state_d  = S_WAIT_DONE;
                    end
                end else if (wdog_hit) begin
                    timeout_err_d = 1'b1;
                    result_d      = '1;
                    state_d       = S_WRITE;
                end
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_step;
                if (ap_done) begin
                    result_d = ap_return;
                    state_d  = S_WRITE;
                end else if (wdog_hit) begin
                    timeout_err_d = 1'b1;
                    result_d      = '1;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                idx_d   = idx_inc;
                state_d = (idx_inc < count_q) ? S_RD_ADDR : S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobe outputs are decoded from the next state so they are registered
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            count_q       <= '0;
            wdog_q        <= '0;
            ap_n_q        <= '0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ap_start_q    <= 1'b0;
            out_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            wdog_q        <= wdog_d;
            ap_n_q        <= ap_n_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_FINISH);
            ap_start_q    <= (state_d == S_CALL);
            out_we_q      <= (state_d == S_WRITE);
        end
    end

    // idx is constant through RD_ADDR..WRITE, so both RAM addresses follow it.
    assign in_addr     = idx_q[ADDR_WIDTH-1:0];
    assign out_addr    = idx_q[ADDR_WIDTH-1:0];
    assign out_d       = result_q;
    assign out_we      = out_we_q;
    assign ap_n        = ap_n_q;
    assign ap_start    = ap_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hls_batch_sequencer
// Description : Scoreboard bench for hls_batch_sequencer. A behavioural
//               argument RAM and a Fibonacci HLS core stub surround the DUT;
//               expected RAM writes are queued when each batch is issued and
//               a monitor pops them as the DUT writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hls_batch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  count;
    logic        busy, done, timeout_err;
    logic [2:0]  in_addr, out_addr;
    logic [63:0] in_q;
    logic [63:0] out_d;
    logic        out_we;
    logic        ap_start, ap_done, ap_idle, ap_ready;
    logic [31:0] ap_n;
    logic [63:0] ap_return;

    always #5 clk = ~clk;

    hls_batch_sequencer #(
        .DATA_WIDTH(64), .ADDR_WIDTH(3), .ARG_WIDTH(32), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .in_addr(in_addr), .in_q(in_q),
        .out_addr(out_addr), .out_d(out_d), .out_we(out_we),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .ap_n(ap_n), .ap_return(ap_return)
    );

    // ---------------- counters and scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_we = 0;
    int n_apstart = 0;
    int n_stall = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [63:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // ---------------- argument RAM: two-edge read latency ----------------
    logic [63:0] mem [8];
    logic [2:0]  ram_addr_r;
    always @(posedge clk) begin
        ram_addr_r <= in_addr;
        in_q       <= mem[ram_addr_r];
    end

    // ---------------- HLS core stub: returns fib(ap_n) ----------------
    int cfg_latency     = 3;
    int cfg_ready_delay = 0;
    int hang_left       = 0;
    bit hang_noready    = 1'b0;

    function automatic logic [63:0] fib(input logic [31:0] n);
        logic [63:0] a = 64'd0;
        logic [63:0] b = 64'd1;
        logic [63:0] t;
        for (int unsigned i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // The stub acts 3 time units after each rising edge, so the monitor at
    // the falling edge sees settled values for the current cycle.
    initial begin
        logic [31:0] arg;
        ap_ready = 1'b0; ap_done = 1'b0; ap_return = 64'd0; ap_idle = 1'b1;
        forever begin
            @(posedge clk); #3;
            ap_ready = 1'b0; ap_done = 1'b0;
            if (ap_start && !rst) begin
                arg = ap_n;
                ap_idle = 1'b0;
                if (hang_left > 0) begin
                    hang_left--;
                    if (hang_noready) begin
                        while (ap_start) begin @(posedge clk); #3; end
                    end else begin
                        ap_ready = 1'b1;
                        @(posedge clk); #3;
                        ap_ready = 1'b0;
                    end
                end else begin
                    repeat (cfg_ready_delay) begin @(posedge clk); #3; end
                    ap_ready = 1'b1;
                    if (cfg_latency == 0) begin ap_done = 1'b1; ap_return = fib(arg); end
                    @(posedge clk); #3;
                    ap_ready = 1'b0; ap_done = 1'b0;
                    if (cfg_latency > 0) begin
                        repeat (cfg_latency - 1) begin @(posedge clk); #3; end
                        ap_done = 1'b1; ap_return = fib(arg);
                        @(posedge clk); #3;
                        ap_done = 1'b0;
                    end
                end
                ap_idle = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit   prev_hs = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_hs) check("ap_start_drop_after_ready", 64'(ap_start), 64'd0);
                prev_hs = ap_start && ap_ready;
                if (ap_start && !ap_ready) n_stall++;
                if (ap_start) n_apstart++;
            end else begin
                prev_hs = 1'b0;
            end
            if (done) n_done++;
            if (out_we) begin
                n_we++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", out_addr, out_d);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(out_addr), 64'(e.addr));
                    check("wr_data", out_d, e.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [3:0] n);
        start = 1'b1; count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},     64'(busy),        64'd0);
        check({tag, "_done"},     64'(done),        64'd0);
        check({tag, "_terr"},     64'(timeout_err), 64'd0);
        check({tag, "_ap_start"}, 64'(ap_start),    64'd0);
        check({tag, "_out_we"},   64'(out_we),      64'd0);
        check({tag, "_in_addr"},  64'(in_addr),     64'd0);
        check({tag, "_out_addr"}, 64'(out_addr),    64'd0);
        check({tag, "_out_d"},    out_d,            64'd0);
        check({tag, "_ap_n"},     64'(ap_n),        64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, w0, s0, a0;
        bit found;
        rst = 1'b1; start = 1'b0; count = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Batch of four, 3-cycle core; upper RAM bits must be truncated.
        mem[0] = {32'hDEAD_BEEF, 32'd0};
        mem[1] = {32'hDEAD_BEEF, 32'd46};
        mem[2] = {32'h1234_5678, 32'd47};
        mem[3] = {32'hFFFF_FFFF, 32'd92};
        push_exp(3'd0, 64'd0);
        push_exp(3'd1, 64'd1836311903);
        push_exp(3'd2, 64'd2971215073);
        push_exp(3'd3, 64'd7540113804746346429);
        d0 = n_done;
        pulse_start(4'd4);
        wait_done("b4_done_seen", 300);
        repeat (3) @(negedge clk);
        check("b4_done_once", 64'(n_done - d0), 64'd1);
        check("b4_timeout_err", 64'(timeout_err), 64'd0);
        check("b4_queue_drained", 64'(exp_q.size()), 64'd0);
        check("b4_idle_busy", 64'(busy), 64'd0);

        // Empty batch: done the cycle after start is sampled, no core call.
        d0 = n_done; w0 = n_we; a0 = n_apstart;
        start = 1'b1; count = 4'd0;
        @(negedge clk);
        start = 1'b0;
        check("empty_done_pulse", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("empty_done_low", 64'(done), 64'd0);
        check("empty_busy_low", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("empty_no_ap_start", 64'(n_apstart - a0), 64'd0);
        check("empty_no_write", 64'(n_we - w0), 64'd0);
        check("empty_done_once", 64'(n_done - d0), 64'd1);

        // Core stalls ap_ready for five cycles.
        cfg_ready_delay = 5;
        mem[0] = {32'hCAFE_F00D, 32'd10};
        push_exp(3'd0, 64'd55);
        s0 = n_stall;
        pulse_start(4'd1);
        wait_done("stall_done_seen", 300);
        repeat (3) @(negedge clk);
        check("stall_cycles", 64'(n_stall - s0), 64'd5);
        check("stall_queue_drained", 64'(exp_q.size()), 64'd0);
        cfg_ready_delay = 0;

        // First call never accepted: watchdog in CALL, batch continues.
        hang_left = 1; hang_noready = 1'b1;
        mem[0] = 64'd3;
        mem[1] = 64'd5;
        push_exp(3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(3'd1, 64'd5);
        pulse_start(4'd2);
        wait_done("wd_call_done_seen", 400);
        check("wd_call_terr", 64'(timeout_err), 64'd1);
        repeat (3) @(negedge clk);
        check("wd_call_queue_drained", 64'(exp_q.size()), 64'd0);

        // First call accepted but never completes: watchdog in WAIT_DONE.
        hang_left = 1; hang_noready = 1'b0;
        mem[0] = 64'd7;
        mem[1] = 64'd6;
        push_exp(3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        push_exp(3'd1, 64'd8);
        pulse_start(4'd2);
        check("wd_wait_terr_cleared", 64'(timeout_err), 64'd0);
        wait_done("wd_wait_done_seen", 400);
        check("wd_wait_terr", 64'(timeout_err), 64'd1);
        repeat (3) @(negedge clk);
        check("wd_wait_queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset while waiting on the core at idx 2: no write to address 2.
        mem[0] = 64'd10; mem[1] = 64'd20; mem[2] = 64'd30; mem[3] = 64'd40;
        push_exp(3'd0, 64'd55);
        push_exp(3'd1, 64'd6765);
        w0 = n_we; d0 = n_done;
        pulse_start(4'd4);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ap_start && (n_we == w0 + 2)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 20 && found; i++) begin
            if (!ap_start) break;
            @(negedge clk);
        end
        check("abort_reached_wait", 64'(found && !ap_start), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_write_idx2", 64'(n_we - w0), 64'd2);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        check("abort_queue_drained", 64'(exp_q.size()), 64'd0);

        // start pulses during a batch are ignored.
        mem[0] = 64'd5; mem[1] = 64'd6; mem[2] = 64'd7;
        push_exp(3'd0, 64'd5);
        push_exp(3'd1, 64'd8);
        push_exp(3'd2, 64'd13);
        d0 = n_done;
        pulse_start(4'd3);
        repeat (6) @(negedge clk);
        pulse_start(4'd1);
        repeat (12) @(negedge clk);
        pulse_start(4'd7);
        wait_done("ignore_done_seen", 300);
        repeat (10) @(negedge clk);
        check("ignore_done_once", 64'(n_done - d0), 64'd1);
        check("ignore_idle", 64'(busy), 64'd0);
        check("ignore_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
